imem_arbiter: RTL and testbench

Shares the single-port instruction memory between two requesters: the instruction-fetch stage (reads) and the program loader (writes). It arbitrates with loader priority and a bounded-starvation rule. It registers the winning request into a one-deep access stage that drives the memory port, and returns fetch data through a 2-entry response FIFO with valid/ready backpressure. It sits between the fetch unit / loader and the instruction memory.

---
 rtl/imem_pkg.sv | 21 ++
 rtl/imem_arbiter_if.sv | 42 ++++
 rtl/imem_rsp_fifo.sv | 57 +++++
 rtl/imem_arbiter.sv | 111 +++++++++++
 tb/tb_imem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared widths, memory size and access-stage payload for the instruction-memory arbiter.
package imem_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 2048;

    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_FETCH = 2'd1,
        ACC_LOAD  = 2'd2
    } acc_t;

    // Request held in the one-deep access stage.
    typedef struct packed {
        acc_t              typ;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } acc_req_t;

endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch, loader and memory-port signals of the instruction-memory arbiter.
interface imem_arbiter_if;
    import imem_pkg::*;

    logic              fetch_req_valid;
    logic [ADDR_W-1:0] fetch_req_addr;
    logic              fetch_req_ready;
    logic              fetch_rsp_valid;
    logic [DATA_W-1:0] fetch_rsp_data;
    logic              fetch_rsp_ready;
    logic              load_req_valid;
    logic [ADDR_W-1:0] load_req_addr;
    logic [DATA_W-1:0] load_req_data;
    logic              load_req_ready;
    logic              load_err;
    logic              mem_rd;
    logic              mem_wn;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    // Arbiter side.
    modport slave (
        input  fetch_req_valid, fetch_req_addr, fetch_rsp_ready,
        input  load_req_valid, load_req_addr, load_req_data,
        input  mem_read_data,
        output fetch_req_ready, fetch_rsp_valid, fetch_rsp_data,
        output load_req_ready, load_err,
        output mem_rd, mem_wn, mem_address, mem_write_data
    );

    // Requester / memory side.
    modport master (
        output fetch_req_valid, fetch_req_addr, fetch_rsp_ready,
        output load_req_valid, load_req_addr, load_req_data,
        output mem_read_data,
        input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_data,
        input  load_req_ready, load_err,
        input  mem_rd, mem_wn, mem_address, mem_write_data
    );

endinterface

// File: rtl/imem_rsp_fifo.sv
// Two-entry fetch response FIFO with same-cycle push/pop and occupancy output.
module imem_rsp_fifo
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              head_valid,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              pop_ok;

    // Pointer, storage and occupancy update.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        pop_ok   = pop && (count_q != 2'd0);
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(push) - 2'(pop_ok);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_valid = (count_q != 2'd0);
    assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;

endmodule

// File: rtl/imem_arbiter.sv
// Loader-priority arbiter with bounded fetch starvation, one-deep access stage
// driving the single-port instruction memory, and fetch response FIFO.
module imem_arbiter
    import imem_pkg::ADDR_W, imem_pkg::DATA_W, imem_pkg::acc_req_t,
           imem_pkg::ACC_NONE, imem_pkg::ACC_FETCH, imem_pkg::ACC_LOAD;
#(
    parameter int unsigned DEPTH        = imem_pkg::DEPTH,
    parameter int unsigned MAX_LOAD_RUN = 4
) (
    input logic           clk,
    input logic           rst_n,
    imem_arbiter_if.slave bus
);

    localparam int unsigned RUN_W = $clog2(MAX_LOAD_RUN + 1);

    acc_req_t          acc_q, acc_d;
    logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
    logic [1:0]        fifo_count;
    logic              fifo_valid;
    logic              fifo_pop;
    logic              fifo_push;
    logic [DATA_W-1:0] fifo_push_data;
    logic [2:0]        occupancy;
    logic              fetch_ok;
    logic              gnt_fetch;
    logic              gnt_load;
    logic              acc_in_range;
    logic              mem_rd_c;
    logic              mem_wn_c;

    // Fetch eligibility and grant selection; nothing is granted while in reset.
    always_comb begin
        fifo_pop  = fifo_valid && bus.fetch_rsp_ready;
        occupancy = 3'(acc_q.typ == ACC_FETCH) + 3'(fifo_count) - 3'(fifo_pop);
        fetch_ok  = (occupancy < 3'd2);
        gnt_fetch = 1'b0;
        gnt_load  = 1'b0;
        if (rst_n) begin
            if (bus.fetch_req_valid && bus.load_req_valid && fetch_ok &&
                (run_cnt_q == RUN_W'(MAX_LOAD_RUN))) begin
                gnt_fetch = 1'b1;
            end else if (bus.load_req_valid) begin
                gnt_load = 1'b1;
            end else if (bus.fetch_req_valid && fetch_ok) begin
                gnt_fetch = 1'b1;
            end
        end
    end

    // Consecutive load grants taken while fetch is waiting and eligible.
    always_comb begin
        run_cnt_d = run_cnt_q;
        if (!bus.fetch_req_valid || gnt_fetch) begin
            run_cnt_d = '0;
        end else if (gnt_load && fetch_ok && (run_cnt_q != RUN_W'(MAX_LOAD_RUN))) begin
            run_cnt_d = run_cnt_q + RUN_W'(1);
        end
    end

    // Next access-stage contents from the winning request.
    always_comb begin
        acc_d = '{typ: ACC_NONE, addr: '0, data: '0};
        if (gnt_load) begin
            acc_d = '{typ: ACC_LOAD, addr: bus.load_req_addr, data: bus.load_req_data};
        end else if (gnt_fetch) begin
            acc_d = '{typ: ACC_FETCH, addr: bus.fetch_req_addr, data: '0};
        end
    end

    // Memory-port decode of the current access; zeroed fields when idle.
    always_comb begin
        acc_in_range   = (32'(acc_q.addr) < DEPTH);
        mem_rd_c       = (acc_q.typ == ACC_FETCH) && acc_in_range;
        mem_wn_c       = (acc_q.typ == ACC_LOAD) && acc_in_range;
        fifo_push      = (acc_q.typ == ACC_FETCH);
        fifo_push_data = mem_rd_c ? bus.mem_read_data : '0;
    end

    // Access stage and run counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '{typ: ACC_NONE, addr: '0, data: '0};
            run_cnt_q <= '0;
        end else begin
            acc_q     <= acc_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    imem_rsp_fifo u_rsp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .push_data  (fifo_push_data),
        .pop        (fifo_pop),
        .head_valid (fifo_valid),
        .head_data  (bus.fetch_rsp_data),
        .count      (fifo_count)
    );

    assign bus.fetch_req_ready = gnt_fetch;
    assign bus.load_req_ready  = gnt_load;
    assign bus.fetch_rsp_valid = fifo_valid;
    assign bus.load_err        = (acc_q.typ == ACC_LOAD) && !acc_in_range;
    assign bus.mem_rd          = mem_rd_c;
    assign bus.mem_wn          = mem_wn_c;
    assign bus.mem_address     = (mem_rd_c || mem_wn_c) ? acc_q.addr : '0;
    assign bus.mem_write_data  = mem_wn_c ? acc_q.data : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized scoreboard bench for imem_arbiter with a program-order memory model.
module tb_imem_arbiter;
    import imem_pkg::*;

    localparam int unsigned MAXRUN = 4;
    localparam int unsigned NWORDS = 2048;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic do_preload;
    logic log_en;

    imem_arbiter_if bus ();

    imem_arbiter #(.DEPTH(NWORDS), .MAX_LOAD_RUN(MAXRUN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Physical memory written only through the DUT strobes.
    logic [31:0] mem_arr [NWORDS];
    always @(posedge clk) begin
        if (do_preload) begin
            for (int k = 0; k < int'(NWORDS); k++) mem_arr[k] <= 32'(k + 1);
        end else if (bus.mem_wn && (32'(bus.mem_address) < NWORDS)) begin
            mem_arr[bus.mem_address[10:0]] <= bus.mem_write_data;
        end
    end
    assign bus.mem_read_data = (32'(bus.mem_address) < NWORDS) ?
                               mem_arr[bus.mem_address[10:0]] : 32'hBAD0_BAD0;

    // Reference state: memory as seen in request order, outstanding responses, load run.
    logic [31:0] ref_mem [NWORDS];
    rsp_t        exp_q [$];
    acc_req_t    exp_acc;
    int          run_m;
    int          cyc;
    int          fetch_acc_cnt;
    byte         gnt_log [$];
    int          tests;
    int          errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon_step();
        logic        in_r, e_rd, e_wn, e_valid, pop, f_ok, gf, gl, fv, lv;
        logic [15:0] fa, la;
        int          pending;
        in_r = 32'(exp_acc.addr) < NWORDS;
        e_rd = (exp_acc.typ == ACC_FETCH) && in_r;
        e_wn = (exp_acc.typ == ACC_LOAD) && in_r;
        check("mem_rd", 32'(bus.mem_rd), 32'(e_rd));
        check("mem_wn", 32'(bus.mem_wn), 32'(e_wn));
        check("mem_address", 32'(bus.mem_address), (e_rd || e_wn) ? 32'(exp_acc.addr) : 32'd0);
        check("mem_write_data", bus.mem_write_data, e_wn ? exp_acc.data : 32'd0);
        check("load_err", 32'(bus.load_err), 32'((exp_acc.typ == ACC_LOAD) && !in_r));

        pending = exp_q.size();
        e_valid = (pending > 0) && ((cyc - exp_q[0].cyc) >= 2);
        check("rsp_valid", 32'(bus.fetch_rsp_valid), 32'(e_valid));
        pop = bus.fetch_rsp_valid && bus.fetch_rsp_ready;
        if (pop && (pending > 0)) begin
            check("rsp_data", bus.fetch_rsp_data, exp_q[0].data);
            void'(exp_q.pop_front());
        end

        f_ok = (pending - int'(pop && (pending > 0))) < 2;
        fv = bus.fetch_req_valid;
        lv = bus.load_req_valid;
        fa = bus.fetch_req_addr;
        la = bus.load_req_addr;
        gf = 1'b0;
        gl = 1'b0;
        if (fv && lv && f_ok && (run_m == int'(MAXRUN))) gf = 1'b1;
        else if (lv) gl = 1'b1;
        else if (fv && f_ok) gf = 1'b1;
        check("fetch_req_ready", 32'(bus.fetch_req_ready), 32'(gf));
        check("load_req_ready", 32'(bus.load_req_ready), 32'(gl));

        if (log_en) begin
            if (bus.load_req_valid && bus.load_req_ready) gnt_log.push_back(8'h4C);
            else if (bus.fetch_req_valid && bus.fetch_req_ready) gnt_log.push_back(8'h46);
            else gnt_log.push_back(8'h2D);
        end
        if (bus.fetch_req_valid && bus.fetch_req_ready) fetch_acc_cnt++;

        if (!fv || gf) run_m = 0;
        else if (gl && f_ok && (run_m < int'(MAXRUN))) run_m++;

        if (gl) begin
            if (32'(la) < NWORDS) ref_mem[la[10:0]] = bus.load_req_data;
            exp_acc = '{typ: ACC_LOAD, addr: la, data: bus.load_req_data};
        end else if (gf) begin
            exp_q.push_back('{data: (32'(fa) < NWORDS) ? ref_mem[fa[10:0]] : 32'd0, cyc: cyc});
            exp_acc = '{typ: ACC_FETCH, addr: fa, data: '0};
        end else begin
            exp_acc = '{typ: ACC_NONE, addr: '0, data: '0};
        end
    endtask

    // Monitor: compares DUT outputs on the falling edge and advances the model.
    initial begin : monitor
        for (int k = 0; k < int'(NWORDS); k++) ref_mem[k] = 32'(k + 1);
        cyc           = 0;
        run_m         = 0;
        fetch_acc_cnt = 0;
        exp_acc       = '{typ: ACC_NONE, addr: '0, data: '0};
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                exp_q.delete();
                run_m   = 0;
                exp_acc = '{typ: ACC_NONE, addr: '0, data: '0};
            end else begin
                mon_step();
            end
        end
    end

    task automatic drive(input logic fv, input logic [15:0] fa, input logic lv,
                         input logic [15:0] la, input logic [31:0] ld, input logic rr);
        @(posedge clk);
        #1;
        bus.fetch_req_valid = fv;
        bus.fetch_req_addr  = fa;
        bus.load_req_valid  = lv;
        bus.load_req_addr   = la;
        bus.load_req_data   = ld;
        bus.fetch_rsp_ready = rr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'd0, 1'b0, 16'd0, 32'd0, 1'b1);
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(7) == 0) return 16'($urandom_range(4095));
        return 16'($urandom_range(63));
    endfunction

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            drive($urandom_range(9) < 6, rand_addr(), $urandom_range(9) < 3, rand_addr(),
                  $urandom, $urandom_range(9) < 7);
        end
    endtask

    task automatic drain();
        int n;
        idle(1);
        n = 0;
        while ((exp_q.size() != 0) && (n < 20)) begin
            idle(1);
            n++;
        end
        check("drain_outstanding", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : stim
        int          base;
        int          idx;
        int          n;
        logic [31:0] old;
        tests  = 0;
        errors = 0;
        log_en = 1'b0;
        rst_n  = 1'b0;
        do_preload          = 1'b1;
        bus.fetch_req_valid = 1'b1;
        bus.fetch_req_addr  = 16'd1;
        bus.load_req_valid  = 1'b1;
        bus.load_req_addr   = 16'd2;
        bus.load_req_data   = 32'h5555_AAAA;
        bus.fetch_rsp_ready = 1'b1;

        // Reset values with both requesters asserting valid.
        @(posedge clk);
        @(posedge clk);
        #1;
        do_preload = 1'b0;
        check("rst_fetch_req_ready", 32'(bus.fetch_req_ready), 32'd0);
        check("rst_load_req_ready", 32'(bus.load_req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.fetch_rsp_valid), 32'd0);
        check("rst_rsp_data", bus.fetch_rsp_data, 32'd0);
        check("rst_load_err", 32'(bus.load_err), 32'd0);
        check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        check("rst_mem_wn", 32'(bus.mem_wn), 32'd0);
        check("rst_mem_address", 32'(bus.mem_address), 32'd0);
        check("rst_mem_write_data", bus.mem_write_data, 32'd0);
        bus.fetch_req_valid = 1'b0;
        bus.load_req_valid  = 1'b0;
        #2;
        rst_n = 1'b1;
        idle(2);

        // Single fetch, then load followed by fetch of the same word.
        drive(1'b1, 16'd3, 1'b0, 16'd0, 32'd0, 1'b1);
        idle(3);
        drive(1'b0, 16'd0, 1'b1, 16'd5, 32'hDEAD_BEEF, 1'b1);
        drive(1'b1, 16'd5, 1'b0, 16'd0, 32'd0, 1'b1);
        idle(3);

        // Both requesters continuously valid: bounded load runs.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'(20 + i), 1'b1, 16'(30 + i), $urandom, 1'b1);
            if (i == 0) log_en = 1'b1;
        end
        idle(1);
        log_en = 1'b0;
        check("grant_log_len", 32'(gnt_log.size()), 32'd10);
        for (int i = 0; i < 10 && i < gnt_log.size(); i++) begin
            check($sformatf("grant_%0d", i), 32'(gnt_log[i]),
                  ((i % (MAXRUN + 1)) == MAXRUN) ? 32'h46 : 32'h4C);
        end
        drain();

        // Backpressure: five fetches offered with the consumer stalled.
        base = fetch_acc_cnt;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            idx = fetch_acc_cnt - base;
            bus.fetch_req_valid = (idx < 5);
            bus.fetch_req_addr  = 16'(10 + idx);
            bus.load_req_valid  = 1'b0;
            bus.fetch_rsp_ready = 1'b0;
        end
        check("bp_accepted_stalled", 32'(fetch_acc_cnt - base), 32'd2);
        check("bp_ready_low", 32'(bus.fetch_req_ready), 32'd0);
        n = 0;
        idx = fetch_acc_cnt - base;
        while ((idx < 5) && (n < 40)) begin
            @(posedge clk);
            #1;
            idx = fetch_acc_cnt - base;
            bus.fetch_req_valid = (idx < 5);
            bus.fetch_req_addr  = 16'(10 + idx);
            bus.fetch_rsp_ready = 1'b1;
            n++;
        end
        check("bp_all_accepted", 32'(fetch_acc_cnt - base), 32'd5);
        drain();

        // Out-of-range load and fetch.
        drive(1'b0, 16'd0, 1'b1, 16'd2048, 32'h1234_5678, 1'b1);
        drive(1'b1, 16'd4000, 1'b0, 16'd0, 32'd0, 1'b1);
        idle(3);

        random_phase(1500);
        drain();

        // Reset while a load occupies the access stage.
        idle(3);
        old = ref_mem[7];
        drive(1'b0, 16'd0, 1'b1, 16'd7, 32'hCAFE_F00D, 1'b1);
        drive(1'b1, 16'd9, 1'b1, 16'd8, 32'h0BAD_0BAD, 1'b1);
        check("pre_rst_mem_wn", 32'(bus.mem_wn), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_mem_wn", 32'(bus.mem_wn), 32'd0);
        check("async_rst_mem_address", 32'(bus.mem_address), 32'd0);
        check("async_rst_load_req_ready", 32'(bus.load_req_ready), 32'd0);
        check("async_rst_fetch_req_ready", 32'(bus.fetch_req_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rst_word_kept", mem_arr[7], old);
        check("rst_rsp_valid_mid", 32'(bus.fetch_rsp_valid), 32'd0);
        ref_mem[7] = old;
        bus.fetch_req_valid = 1'b0;
        bus.load_req_valid  = 1'b0;
        #1;
        rst_n = 1'b1;
        idle(2);
        drive(1'b1, 16'd7, 1'b0, 16'd0, 32'd0, 1'b1);
        idle(3);

        random_phase(300);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
